// File: rtl/gemm_tiled_array_top.sv
// rtl/gemm_tiled_array_top.sv - tiled output-stationary GeMM engine walking all (M,N) tiles
// One C word per RowPar x ColPar tile; partial edge tiles are zero-masked.
module gemm_tiled_array_top #(
    parameter int InDataWidth   = 8,
    parameter int OutDataWidth  = 32,
    parameter int AddrWidth     = 16,
    parameter int SizeAddrWidth = 8,
    parameter int RowPar        = 4,
    parameter int ColPar        = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic                                   signed_i,
    input  logic [SizeAddrWidth-1:0]               M_size_i,
    input  logic [SizeAddrWidth-1:0]               K_size_i,
    input  logic [SizeAddrWidth-1:0]               N_size_i,
    output logic [AddrWidth-1:0]                   sram_a_addr_o,
    output logic [AddrWidth-1:0]                   sram_b_addr_o,
    input  logic [RowPar*InDataWidth-1:0]          sram_a_rdata_i,
    input  logic [ColPar*InDataWidth-1:0]          sram_b_rdata_i,
    output logic [AddrWidth-1:0]                   sram_c_addr_o,
    output logic [RowPar*ColPar*OutDataWidth-1:0]  sram_c_wdata_o,
    output logic                                   sram_c_we_o,
    output logic                                   busy_o,
    output logic                                   done_o
);
    localparam int ExtW = SizeAddrWidth + 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_e;

    state_e                    state_q;
    logic                      signed_q;
    logic [SizeAddrWidth-1:0]  m_q, k_size_q, n_q, k_cnt_q;
    logic [ExtW-1:0]           mt_last_q, nt_last_q, mt_q, nt_q, row_base_q, col_base_q;
    logic [AddrWidth-1:0]      a_base_q, b_base_q, a_addr_q, b_addr_q, c_addr_q;
    logic                      we_q, busy_q, done_q, valid_q, first_q;
    logic [OutDataWidth-1:0]   acc_q [RowPar][ColPar];
    logic [OutDataWidth-1:0]   prod  [RowPar][ColPar];

    logic [ExtW-1:0]           mt_cnt_d, nt_cnt_d;
    logic [AddrWidth-1:0]      a_base_d, b_base_d;
    logic                      size_zero;

    assign mt_cnt_d  = ({1'b0, M_size_i} + ExtW'(RowPar - 1)) >> $clog2(RowPar);
    assign nt_cnt_d  = ({1'b0, N_size_i} + ExtW'(ColPar - 1)) >> $clog2(ColPar);
    assign a_base_d  = a_base_q + AddrWidth'(k_size_q);
    assign b_base_d  = b_base_q + AddrWidth'(k_size_q);
    assign size_zero = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);

    function automatic logic [OutDataWidth-1:0] extend(input logic [InDataWidth-1:0] v,
                                                       input logic s);
        extend = {{(OutDataWidth-InDataWidth){s & v[InDataWidth-1]}}, v};
    endfunction

    // Extending to the full accumulator width first makes the truncated product exact mod 2^OutDataWidth.
    always_comb begin
        for (int r = 0; r < RowPar; r++) begin
            for (int c = 0; c < ColPar; c++) begin
                prod[r][c] = extend(sram_a_rdata_i[r*InDataWidth +: InDataWidth], signed_q)
                           * extend(sram_b_rdata_i[c*InDataWidth +: InDataWidth], signed_q);
            end
        end
    end

    always_comb begin
        sram_c_wdata_o = '0;
        for (int r = 0; r < RowPar; r++) begin
            for (int c = 0; c < ColPar; c++) begin
                if (((row_base_q + ExtW'(r)) < {1'b0, m_q}) &&
                    ((col_base_q + ExtW'(c)) < {1'b0, n_q})) begin
                    sram_c_wdata_o[(r*ColPar+c)*OutDataWidth +: OutDataWidth] = acc_q[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            signed_q   <= 1'b0;
            m_q        <= '0;
            k_size_q   <= '0;
            n_q        <= '0;
            k_cnt_q    <= '0;
            mt_last_q  <= '0;
            nt_last_q  <= '0;
            mt_q       <= '0;
            nt_q       <= '0;
            row_base_q <= '0;
            col_base_q <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            c_addr_q   <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            for (int r = 0; r < RowPar; r++)
                for (int c = 0; c < ColPar; c++)
                    acc_q[r][c] <= '0;
        end else begin
            // Read data lags the address by one cycle; the k=0 word clears the tile implicitly.
            valid_q <= (state_q == S_RUN);
            first_q <= (state_q == S_RUN) && (k_cnt_q == '0);
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            if (valid_q) begin
                for (int r = 0; r < RowPar; r++)
                    for (int c = 0; c < ColPar; c++)
                        acc_q[r][c] <= first_q ? prod[r][c] : acc_q[r][c] + prod[r][c];
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        signed_q   <= signed_i;
                        m_q        <= M_size_i;
                        k_size_q   <= K_size_i;
                        n_q        <= N_size_i;
                        mt_last_q  <= mt_cnt_d - ExtW'(1);
                        nt_last_q  <= nt_cnt_d - ExtW'(1);
                        mt_q       <= '0;
                        nt_q       <= '0;
                        row_base_q <= '0;
                        col_base_q <= '0;
                        a_base_q   <= '0;
                        b_base_q   <= '0;
                        a_addr_q   <= '0;
                        b_addr_q   <= '0;
                        c_addr_q   <= '0;
                        k_cnt_q    <= '0;
                        if (size_zero) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (k_cnt_q == k_size_q - SizeAddrWidth'(1)) begin
                        state_q <= S_DRAIN;
                    end else begin
                        k_cnt_q  <= k_cnt_q + SizeAddrWidth'(1);
                        a_addr_q <= a_addr_q + AddrWidth'(1);
                        b_addr_q <= b_addr_q + AddrWidth'(1);
                    end
                end
                S_DRAIN: begin
                    state_q <= S_WRITE;
                    we_q    <= 1'b1;
                end
                S_WRITE: begin
                    c_addr_q <= c_addr_q + AddrWidth'(1);
                    k_cnt_q  <= '0;
                    if (nt_q == nt_last_q) begin
                        if (mt_q == mt_last_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_RUN;
                            mt_q       <= mt_q + ExtW'(1);
                            nt_q       <= '0;
                            row_base_q <= row_base_q + ExtW'(RowPar);
                            col_base_q <= '0;
                            a_base_q   <= a_base_d;
                            a_addr_q   <= a_base_d;
                            b_base_q   <= '0;
                            b_addr_q   <= '0;
                        end
                    end else begin
                        state_q    <= S_RUN;
                        nt_q       <= nt_q + ExtW'(1);
                        col_base_q <= col_base_q + ExtW'(ColPar);
                        b_base_q   <= b_base_d;
                        b_addr_q   <= b_base_d;
                        a_addr_q   <= a_base_q;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sram_a_addr_o = a_addr_q;
    assign sram_b_addr_o = b_addr_q;
    assign sram_c_addr_o = c_addr_q;
    assign sram_c_we_o   = we_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_gemm_tiled_array_top.sv
// tb/tb_gemm_tiled_array_top.sv - randomized bench for gemm_tiled_array_top against a matrix model
// SRAMs are modelled with one-cycle read latency; expected tiles come from plain triple-loop GeMM.
module tb_gemm_tiled_array_top;
    localparam int IW = 8, OW = 32, AW = 16, SW = 8, RP = 4, CP = 16;

    logic                  clk, rst_n, start, sgn;
    logic [SW-1:0]         m_size, k_size, n_size;
    logic [AW-1:0]         a_addr, b_addr, c_addr;
    logic [RP*IW-1:0]      a_rdata;
    logic [CP*IW-1:0]      b_rdata;
    logic [RP*CP*OW-1:0]   wdata;
    logic                  we, busy, done;

    gemm_tiled_array_top #(
        .InDataWidth(IW), .OutDataWidth(OW), .AddrWidth(AW),
        .SizeAddrWidth(SW), .RowPar(RP), .ColPar(CP)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .signed_i(sgn),
        .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
        .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr),
        .sram_a_rdata_i(a_rdata), .sram_b_rdata_i(b_rdata),
        .sram_c_addr_o(c_addr), .sram_c_wdata_o(wdata), .sram_c_we_o(we),
        .busy_o(busy), .done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [RP*IW-1:0] a_mem [0:1023];
    logic [CP*IW-1:0] b_mem [0:1023];
    always @(posedge clk) begin
        a_rdata <= a_mem[a_addr[9:0]];
        b_rdata <= b_mem[b_addr[9:0]];
    end

    int a_mat [0:15][0:7];
    int b_mat [0:7][0:47];

    int checks = 0, failures = 0;
    int edges = 0, start_edge = 0, done_cnt = 0, done_lat = 0;
    logic busy_at_done;
    logic [AW-1:0]       wr_addr [$];
    logic [RP*CP*OW-1:0] wr_data [$];

    always @(posedge clk) edges++;

    always @(negedge clk) begin
        if (we) begin
            wr_addr.push_back(c_addr);
            wr_data.push_back(wdata);
        end
        if (done) begin
            if (done_cnt == 0) begin
                done_lat     = edges - start_edge;
                busy_at_done = busy;
            end
            done_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint elem_val(input int raw, input bit s);
        logic [7:0] b8;
        b8 = raw[7:0];
        if (s) return longint'($signed(b8));
        return longint'(b8);
    endfunction

    // mode 0: random matrices; mode 1: A=1, B=column index; mode 2: A=av, B=bv everywhere
    task automatic run_gemm(input int m, input int k, input int n, input bit s,
                            input int mode, input int av, input int bv, input bit poke);
        int mt_n, nt_n, n_exp, cyc, w, mt, nt, row, col;
        logic [RP*IW-1:0] aw;
        logic [CP*IW-1:0] bw;
        logic [OW-1:0] exp_e, obs_e;
        longint acc;
        bit zero;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 8; j++)
                a_mat[i][j] = (mode == 0) ? int'($urandom_range(0, 255)) : (mode == 1 ? 1 : av);
        for (int j = 0; j < 8; j++)
            for (int c = 0; c < 48; c++)
                b_mat[j][c] = (mode == 0) ? int'($urandom_range(0, 255)) : (mode == 1 ? c : bv);
        mt_n = (m + RP - 1) / RP;
        nt_n = (n + CP - 1) / CP;
        zero = (m == 0) || (k == 0) || (n == 0);
        for (int t = 0; t < mt_n; t++)
            for (int kk = 0; kk < k; kk++) begin
                for (int r = 0; r < RP; r++) aw[r*IW +: IW] = a_mat[t*RP+r][kk][7:0];
                a_mem[t*k+kk] = aw;
            end
        for (int t = 0; t < nt_n; t++)
            for (int kk = 0; kk < k; kk++) begin
                for (int c = 0; c < CP; c++) bw[c*IW +: IW] = b_mat[kk][t*CP+c][7:0];
                b_mem[t*k+kk] = bw;
            end
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;

        @(negedge clk); #1;
        start = 1'b1; sgn = s;
        m_size = SW'(m); k_size = SW'(k); n_size = SW'(n);
        start_edge = edges;
        @(negedge clk); #1;
        start = 1'b0;
        sgn = 1'($urandom); m_size = SW'($urandom); k_size = SW'($urandom); n_size = SW'($urandom);
        check_eq("busy_after_start", 64'(busy), zero ? 64'd0 : 64'd1);
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            start = poke && (cyc == 1);
            @(negedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check_eq("done_seen", 64'(done_cnt > 0), 64'd1);
        check_eq("done_latency", 64'(done_lat), zero ? 64'd1 : 64'(1 + mt_n*nt_n*(k+2)));
        check_eq("busy_at_done", 64'(busy_at_done), 64'd0);
        repeat (6) @(negedge clk);
        #1;
        check_eq("done_pulses", 64'(done_cnt), 64'd1);

        n_exp = zero ? 0 : mt_n * nt_n;
        check_eq("write_count", 64'(wr_addr.size()), 64'(n_exp));
        for (w = 0; w < n_exp && w < wr_addr.size(); w++) begin
            mt = w / nt_n;
            nt = w % nt_n;
            check_eq($sformatf("c_addr[%0d]", w), 64'(wr_addr[w]), 64'(mt*nt_n + nt));
            for (int r = 0; r < RP; r++)
                for (int c = 0; c < CP; c++) begin
                    row = mt*RP + r;
                    col = nt*CP + c;
                    acc = 0;
                    if (row < m && col < n)
                        for (int kk = 0; kk < k; kk++)
                            acc += elem_val(a_mat[row][kk], s) * elem_val(b_mat[kk][col], s);
                    exp_e = acc[OW-1:0];
                    obs_e = wr_data[w][(r*CP+c)*OW +: OW];
                    check_eq($sformatf("m%0d_k%0d_n%0d_t%0d_e%0d_%0d", m, k, n, w, r, c),
                             64'(obs_e), 64'(exp_e));
                end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0;
        m_size = '0; k_size = '0; n_size = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_we", 64'(we), 64'd0);
        check_eq("rst_a_addr", 64'(a_addr), 64'd0);
        check_eq("rst_c_addr", 64'(c_addr), 64'd0);
        check_eq("rst_wdata_lo", wdata[63:0], 64'd0);
        rst_n = 1'b1;

        run_gemm(4, 1, 16, 1'b1, 1, 0, 0, 1'b0);
        run_gemm(8, 3, 32, 1'b1, 0, 0, 0, 1'b0);
        run_gemm(5, 2, 17, 1'b1, 0, 0, 0, 1'b0);
        run_gemm(5, 2, 17, 1'b0, 0, 0, 0, 1'b0);
        run_gemm(4, 4, 16, 1'b1, 2, 8'h80, 8'h80, 1'b0);
        run_gemm(4, 4, 16, 1'b0, 2, 8'h80, 8'h80, 1'b0);
        run_gemm(4, 1, 16, 1'b1, 2, 8'hFF, 8'hFF, 1'b0);
        run_gemm(4, 1, 16, 1'b0, 2, 8'hFF, 8'hFF, 1'b0);
        run_gemm(4, 0, 16, 1'b1, 0, 0, 0, 1'b0);
        run_gemm(8, 3, 32, 1'b0, 0, 0, 0, 1'b1);

        // abort a run mid-RUN, then confirm a fresh run starts from clean accumulators
        @(negedge clk); #1;
        start = 1'b1; sgn = 1'b1; m_size = 8'd8; k_size = 8'd5; n_size = 8'd32;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_we", 64'(we), 64'd0);
        check_eq("abort_a_addr", 64'(a_addr), 64'd0);
        check_eq("abort_b_addr", 64'(b_addr), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        run_gemm(4, 2, 16, 1'b1, 0, 0, 0, 1'b0);

        for (int i = 0; i < 4; i++)
            run_gemm(int'($urandom_range(1, 12)), int'($urandom_range(1, 6)),
                     int'($urandom_range(1, 40)), 1'($urandom), 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
